// File: rtl/riscv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_enc_pkg
// Description : Shared RV32I encode/decode definitions: instruction formats,
//               major opcodes and immediate range limits.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_enc_pkg;

    typedef enum logic [1:0] {
        FMT_LOAD   = 2'd0,
        FMT_JALR   = 2'd1,
        FMT_STORE  = 2'd2,
        FMT_BRANCH = 2'd3
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // 12-bit immediates (I/S) and 13-bit branch offsets (B, even only)
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

endpackage : riscv_enc_pkg
`default_nettype wire

// File: rtl/inst_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_pack
// Description : Combinational packer: format + register fields + signed
//               immediate -> 32-bit RV32I word and a legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        legal
);

    logic signed [31:0] imm_s;

    assign imm_s = $signed(imm);

    // Field placement and immediate range check per instruction format
    always_comb begin
        inst  = 32'h0;
        legal = 1'b0;
        case (fmt)
            FMT_LOAD: begin
                inst  = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
                legal = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_JALR: begin
                inst  = {imm[11:0], rs1, funct3, rd, OPC_JALR};
                legal = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_STORE: begin
                inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
                legal = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_BRANCH: begin
                inst  = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], OPC_BRANCH};
                // branch offsets are in 2-byte units, so bit 0 must be clear
                legal = (imm_s >= IMM13_MIN) && (imm_s <= IMM13_MAX) && !imm[0];
            end
            default: begin
                inst  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule : imm_pack
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Packs instruction fields into RV32I words for the instruction
//               memory, with a 1-entry output register, wrapping write
//               address and a saturating count of dropped illegal requests.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import riscv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter int          ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  fmt_e                 in_fmt,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (IMEM_WORDS - 1));

    logic [31:0] packed_inst;
    logic        packed_legal;
    logic        accept;
    logic        out_fire;

    imm_pack u_imm_pack (
        .fmt    (in_fmt),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .imm    (in_imm),
        .inst   (packed_inst),
        .legal  (packed_legal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Output register: load legal words, drop valid once the consumer takes it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
        end else if (accept && packed_legal) begin
            out_valid <= 1'b1;
            out_inst  <= packed_inst;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Write address advances per delivered word and wraps at memory end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_addr <= BASE_ADDR;
        end else if (out_fire) begin
            out_addr <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
        end
    end

    // Illegal requests are consumed silently but flagged and counted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !packed_legal;
            if (accept && !packed_legal && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule : inst_encoder
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed bench for inst_encoder with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
    import riscv_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    fmt_e        in_fmt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    inst_encoder #(
        .BASE_ADDR  (BASE),
        .IMEM_WORDS (4),
        .ERR_CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Decode-side B-type immediate generator
    function automatic logic [31:0] immgen_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input fmt_e f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = f;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = FMT_LOAD; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        step(); step();
        reset_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== BASE ||
            err_pulse !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: valid=%b inst=%h addr=%h pulse=%b cnt=%0d rdy=%b, want 0/0/%h/0/0/1",
                     out_valid, out_inst, out_addr, err_pulse, err_count, in_ready, BASE);
        end
    endtask

    task automatic test_load();
        drive(FMT_LOAD, 5'd5, 5'd2, 5'd0, 3'd2, -32'sd4);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_inst !== 32'hFFC12283 || out_addr !== BASE) begin
            miscompares++;
            $display("FAIL load: valid=%b inst=%h addr=%h, want 1/FFC12283/%h",
                     out_valid, out_inst, out_addr, BASE);
        end
    endtask

    // STORE accepted in the same cycle the LOAD word is handed off
    task automatic test_back_to_back();
        drive(FMT_STORE, 5'd0, 5'd2, 5'd6, 3'd2, 32'd8);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_inst !== 32'h00612423 || out_addr !== BASE + 32'd4) begin
            miscompares++;
            $display("FAIL store: valid=%b inst=%h addr=%h, want 1/00612423/%h",
                     out_valid, out_inst, out_addr, BASE + 32'd4);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_addr !== BASE + 32'd8) begin
            miscompares++;
            $display("FAIL drain: valid=%b addr=%h, want 0/%h", out_valid, out_addr, BASE + 32'd8);
        end
    endtask

    task automatic test_branch();
        drive(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_inst !== 32'hFE208CE3 || out_addr !== BASE + 32'd8) begin
            miscompares++;
            $display("FAIL branch: valid=%b inst=%h addr=%h, want 1/FE208CE3/%h",
                     out_valid, out_inst, out_addr, BASE + 32'd8);
        end
        vectors++;
        if (immgen_b(out_inst) !== 32'hFFFFFFF8) begin
            miscompares++;
            $display("FAIL roundtrip: imm=%h, want FFFFFFF8", immgen_b(out_inst));
        end
        step();
    endtask

    task automatic test_illegal();
        drive(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        step();
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_odd: pulse=%b cnt=%0d valid=%b, want 1/1/0",
                     err_pulse, err_count, out_valid);
        end
        drive(FMT_LOAD, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048);
        step();
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0 ||
            out_addr !== BASE + 32'd12) begin
            miscompares++;
            $display("FAIL illegal_2048: pulse=%b cnt=%0d valid=%b addr=%h, want 1/2/0/%h",
                     err_pulse, err_count, out_valid, out_addr, BASE + 32'd12);
        end
        drive(FMT_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096);
        step();
        drive(FMT_STORE, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2049);
        step();
        in_valid = 1'b0;
        vectors++;
        if (err_count !== 8'd4 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_bounds: cnt=%0d valid=%b, want 4/0", err_count, out_valid);
        end
        step();
        vectors++;
        if (err_pulse !== 1'b0 || err_count !== 8'd4) begin
            miscompares++;
            $display("FAIL pulse_clear: pulse=%b cnt=%0d, want 0/4", err_pulse, err_count);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(FMT_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047);
        step();
        drive(FMT_JALR, 5'd1, 5'd1, 5'd0, 3'd0, -32'sd2048);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h7FF00083 ||
                out_addr !== BASE + 32'd12) begin
                miscompares++;
                $display("FAIL stall[%0d]: rdy=%b valid=%b inst=%h addr=%h, want 0/1/7FF00083/%h",
                         i, in_ready, out_valid, out_inst, out_addr, BASE + 32'd12);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: rdy=%b, want 1", in_ready);
        end
        step();
        vectors++;
        if (out_inst !== 32'h800080E7 || out_addr !== BASE || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap: inst=%h addr=%h valid=%b, want 800080E7/%h/1",
                     out_inst, out_addr, out_valid, BASE);
        end
        drive(FMT_BRANCH, 5'd0, 5'd0, 5'd0, 3'd1, 32'd4094);
        step();
        vectors++;
        if (out_inst !== 32'h7E001FE3 || out_addr !== BASE + 32'd4) begin
            miscompares++;
            $display("FAIL branch_max: inst=%h addr=%h, want 7E001FE3/%h",
                     out_inst, out_addr, BASE + 32'd4);
        end
        drive(FMT_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4096);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_inst !== 32'h80000063 || out_addr !== BASE + 32'd8 || err_count !== 8'd4) begin
            miscompares++;
            $display("FAIL branch_min: inst=%h addr=%h cnt=%0d, want 80000063/%h/4",
                     out_inst, out_addr, err_count, BASE + 32'd8);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_inst !== 32'h80000063) begin
            miscompares++;
            $display("FAIL pre_reset_hold: valid=%b inst=%h, want 1/80000063", out_valid, out_inst);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_addr !== BASE || err_count !== 8'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_stall_reset: valid=%b addr=%h cnt=%0d rdy=%b, want 0/%h/0/1",
                     out_valid, out_addr, err_count, in_ready, BASE);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_stall();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inst_encoder
`default_nettype wire
